// File: rtl/power_status_filter_if.sv
// Bundle of raw status inputs and qualified outputs for power_status_filter.
// The master drives the raw pins and GLITCHCLR; the slave (the filter) returns the qualified view.
interface power_status_filter_if;
  logic       PWRSTAT;
  logic       MRST;
  logic       nMPSSEEN;
  logic       GLITCHCLR;
  logic       PWRSTAT_F;
  logic       MRST_F;
  logic       nMPSSEEN_F;
  logic [1:0] MODE;
  logic       MODE_VALID;
  logic       MODE_CHG;
  logic [7:0] GLITCHCNT;

  modport master (
    output PWRSTAT, MRST, nMPSSEEN, GLITCHCLR,
    input  PWRSTAT_F, MRST_F, nMPSSEEN_F, MODE, MODE_VALID, MODE_CHG, GLITCHCNT
  );

  modport slave (
    input  PWRSTAT, MRST, nMPSSEEN, GLITCHCLR,
    output PWRSTAT_F, MRST_F, nMPSSEEN_F, MODE, MODE_VALID, MODE_CHG, GLITCHCNT
  );
endinterface

// File: rtl/power_status_filter.sv
// Synchronizes and debounces the raw power-mux/board status pins into the MCLK domain and
// presents a qualified MODE with valid flag, change strobe and a saturating glitch counter.
module power_status_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 48000,
  parameter int CNTW        = 16
) (
  input logic                  MCLK,
  input logic                  nRST,
  power_status_filter_if.slave bus
);

  localparam int N_IN      = 3;
  localparam int IDX_PWR   = 0;
  localparam int IDX_MRST  = 1;
  localparam int IDX_MPSSE = 2;

  // Idle levels: motherboard-powered, PCB power good, MPSSE not requested.
  localparam logic [N_IN-1:0] RST_VAL   = 3'b110;
  localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEBOUNCE - 1);
  localparam logic [CNTW-1:0] DEB_FULL  = CNTW'(DEBOUNCE);
  localparam int              INITW     = $clog2(SYNC_STAGES + 1);
  localparam logic [INITW-1:0] INIT_LAST = INITW'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // Raw pins and synchronizer chains
  logic [N_IN-1:0]                  raw;
  logic [N_IN-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [N_IN-1:0]                  sync_last;

  // Filtered levels and debounce counters
  logic [N_IN-1:0]           filt_q, filt_d;
  logic [N_IN-1:0][CNTW-1:0] cnt_q, cnt_d;

  // Debounce proposals, applied by the FSM only once the filters are seeded
  logic [N_IN-1:0]           deb_filt;
  logic [N_IN-1:0][CNTW-1:0] deb_cnt;
  logic [N_IN-1:0]           glitch_ev;
  logic                      all_quiet;

  // Startup control
  state_t           state_q, state_d;
  logic [INITW-1:0] init_q, init_d;
  logic [CNTW-1:0]  settle_q, settle_d, settle_inc;
  logic             valid_q, valid_d;
  logic             count_en;

  // Mode tracking and diagnostics
  logic [1:0] mode;
  logic [1:0] mode_prev_q, mode_prev_d;
  logic       chg_q, chg_d;
  logic [7:0] gcnt_q, gcnt_d;
  logic [1:0] glitch_sum;
  logic [8:0] gcnt_sum;

  assign raw = {bus.nMPSSEEN, bus.MRST, bus.PWRSTAT};

  // Only the last stage of each chain is allowed to reach downstream logic.
  always_comb begin
    // NOTE: every variable driven here is assigned a default first, so no path leaves
    // it unassigned and no latch is inferred.
    sync_d    = sync_q;
    sync_last = '0;
    for (int i = 0; i < N_IN; i++) begin
      sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      sync_last[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_comb begin
    deb_filt  = filt_q;
    deb_cnt   = cnt_q;
    glitch_ev = '0;
    all_quiet = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (sync_last[i] != filt_q[i]) begin
        all_quiet = 1'b0;
        if (cnt_q[i] == DEB_LAST) begin
          deb_filt[i] = sync_last[i];
          deb_cnt[i]  = '0;
        end else begin
          deb_cnt[i] = cnt_q[i] + CNTW'(1);
        end
      end else if (cnt_q[i] != '0) begin
        // Level fell back before acceptance: discard progress and report a glitch.
        all_quiet    = 1'b0;
        deb_cnt[i]   = '0;
        glitch_ev[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_d     = init_q;
    settle_d   = settle_q;
    settle_inc = settle_q + CNTW'(1);
    valid_d    = valid_q;
    filt_d     = filt_q;
    cnt_d      = cnt_q;
    count_en   = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Wait until the chains hold real samples, then seed the filters without debounce.
        if (init_q == INIT_LAST) begin
          filt_d  = sync_last;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          init_d = init_q + INITW'(1);
        end
      end

      ST_SETTLE: begin
        filt_d   = deb_filt;
        cnt_d    = deb_cnt;
        count_en = 1'b1;
        if (all_quiet) begin
          settle_d = settle_inc;
          if (settle_inc == DEB_FULL) begin
            state_d = ST_RUN;
            valid_d = 1'b1;
          end
        end else begin
          settle_d = '0;
        end
      end

      ST_RUN: begin
        filt_d   = deb_filt;
        cnt_d    = deb_cnt;
        count_en = 1'b1;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // MODE_CHG is registered one edge after the change; nMPSSEEN is not part of MODE.
  always_comb begin
    mode        = {filt_q[IDX_PWR], filt_q[IDX_MRST]};
    mode_prev_d = mode;
    chg_d       = valid_q && (mode != mode_prev_q);
  end

  always_comb begin
    glitch_sum = 2'(glitch_ev[IDX_PWR]   & count_en)
               + 2'(glitch_ev[IDX_MRST]  & count_en)
               + 2'(glitch_ev[IDX_MPSSE] & count_en);
    gcnt_sum   = {1'b0, gcnt_q} + 9'(glitch_sum);
    if (bus.GLITCHCLR) begin
      gcnt_d = '0;
    end else if (gcnt_sum[8]) begin
      gcnt_d = 8'hFF;
    end else begin
      gcnt_d = gcnt_sum[7:0];
    end
  end

  always_ff @(posedge MCLK or negedge nRST) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    if (!nRST) begin
      for (int i = 0; i < N_IN; i++) begin
        sync_q[i] <= {SYNC_STAGES{RST_VAL[i]}};
      end
      filt_q      <= RST_VAL;
      cnt_q       <= '0;
      state_q     <= ST_INIT;
      init_q      <= '0;
      settle_q    <= '0;
      valid_q     <= 1'b0;
      mode_prev_q <= {RST_VAL[IDX_PWR], RST_VAL[IDX_MRST]};
      chg_q       <= 1'b0;
      gcnt_q      <= '0;
    end else begin
      sync_q      <= sync_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      init_q      <= init_d;
      settle_q    <= settle_d;
      valid_q     <= valid_d;
      mode_prev_q <= mode_prev_d;
      chg_q       <= chg_d;
      gcnt_q      <= gcnt_d;
    end
  end

  assign bus.PWRSTAT_F  = filt_q[IDX_PWR];
  assign bus.MRST_F     = filt_q[IDX_MRST];
  assign bus.nMPSSEEN_F = filt_q[IDX_MPSSE];
  assign bus.MODE       = mode;
  assign bus.MODE_VALID = valid_q;
  assign bus.MODE_CHG   = chg_q;
  assign bus.GLITCHCNT  = gcnt_q;

endmodule

// File: tb/tb_power_status_filter.sv
// Directed bench for power_status_filter with SYNC_STAGES=2, DEBOUNCE=8: a per-edge vector
// table for startup and single-input changes, then hand sequences for the multi-cycle corners.
module tb_power_status_filter;

  logic MCLK = 1'b0;
  logic nRST;

  power_status_filter_if bus ();

  power_status_filter #(
    .SYNC_STAGES(2),
    .DEBOUNCE   (8),
    .CNTW       (16)
  ) dut (
    .MCLK(MCLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 MCLK = ~MCLK;

  // in    = {PWRSTAT, MRST, nMPSSEEN, GLITCHCLR} applied before the edge
  // flags = {MODE_VALID, MODE_CHG, nMPSSEEN_F} expected after the edge
  typedef struct {
    logic [3:0] in;
    logic [1:0] mode;
    logic [2:0] flags;
    logic [7:0] gcnt;
  } vec_t;

  localparam int N_VEC = 36;
  vec_t tbl [N_VEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] in, input logic [1:0] mode,
                              input logic [2:0] flags, input logic [7:0] gcnt);
    vec_t v;
    v.in    = in;
    v.mode  = mode;
    v.flags = flags;
    v.gcnt  = gcnt;
    return v;
  endfunction

  task automatic fill(input int first, input int last, input vec_t v);
    for (int e = first; e <= last; e++) tbl[e-1] = v;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " MODE"},       32'(bus.MODE),       32'(2'b01));
    check({tag, " MODE_VALID"}, 32'(bus.MODE_VALID), 32'(1'b0));
    check({tag, " MODE_CHG"},   32'(bus.MODE_CHG),   32'(1'b0));
    check({tag, " GLITCHCNT"},  32'(bus.GLITCHCNT),  32'(8'd0));
    check({tag, " PWRSTAT_F"},  32'(bus.PWRSTAT_F),  32'(1'b0));
    check({tag, " MRST_F"},     32'(bus.MRST_F),     32'(1'b1));
    check({tag, " nMPSSEEN_F"}, 32'(bus.nMPSSEEN_F), 32'(1'b1));
  endtask

  // Replays the startup timeline from a fresh reset release: MODE=00 from edge 3, valid from 11.
  task automatic check_startup(input string tag);
    logic [1:0] exp_mode;
    logic       exp_valid;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_mode  = (e >= 3)  ? 2'b00 : 2'b01;
      exp_valid = (e >= 11) ? 1'b1  : 1'b0;
      check($sformatf("%s e%0d MODE", tag, e),       32'(bus.MODE),       32'(exp_mode));
      check($sformatf("%s e%0d MODE_VALID", tag, e), 32'(bus.MODE_VALID), 32'(exp_valid));
      check($sformatf("%s e%0d MODE_CHG", tag, e),   32'(bus.MODE_CHG),   32'(1'b0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int  chg_pulses;
    int  chg_edge;
    logic seen_bad;
    logic [1:0] mode_t9;
    logic [1:0] mode_t10;

    // Edges counted from reset release; MRST change sampled first at edge 13 lands at 22,
    // nMPSSEEN change sampled first at edge 25 lands at 34 and never pulses MODE_CHG.
    fill(1,  2,  mk(4'b0010, 2'b01, 3'b001, 8'd0));
    fill(3,  10, mk(4'b0010, 2'b00, 3'b001, 8'd0));
    fill(11, 12, mk(4'b0010, 2'b00, 3'b101, 8'd0));
    fill(13, 21, mk(4'b0110, 2'b00, 3'b101, 8'd0));
    fill(22, 22, mk(4'b0110, 2'b01, 3'b101, 8'd0));
    fill(23, 23, mk(4'b0110, 2'b01, 3'b111, 8'd0));
    fill(24, 24, mk(4'b0110, 2'b01, 3'b101, 8'd0));
    fill(25, 33, mk(4'b0100, 2'b01, 3'b101, 8'd0));
    fill(34, 36, mk(4'b0100, 2'b01, 3'b100, 8'd0));

    bus.PWRSTAT   = 1'b0;
    bus.MRST      = 1'b0;
    bus.nMPSSEEN  = 1'b1;
    bus.GLITCHCLR = 1'b0;
    nRST          = 1'b1;
    #2 nRST = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (2) tick();
    nRST = 1'b1;

    // Startup, MRST rise, nMPSSEEN fall
    for (int k = 0; k < N_VEC; k++) begin
      bus.PWRSTAT   = tbl[k].in[3];
      bus.MRST      = tbl[k].in[2];
      bus.nMPSSEEN  = tbl[k].in[1];
      bus.GLITCHCLR = tbl[k].in[0];
      tick();
      check($sformatf("vec e%0d MODE", k+1),       32'(bus.MODE),       32'(tbl[k].mode));
      check($sformatf("vec e%0d PWRSTAT_F", k+1),  32'(bus.PWRSTAT_F),  32'(tbl[k].mode[1]));
      check($sformatf("vec e%0d MRST_F", k+1),     32'(bus.MRST_F),     32'(tbl[k].mode[0]));
      check($sformatf("vec e%0d MODE_VALID", k+1), 32'(bus.MODE_VALID), 32'(tbl[k].flags[2]));
      check($sformatf("vec e%0d MODE_CHG", k+1),   32'(bus.MODE_CHG),   32'(tbl[k].flags[1]));
      check($sformatf("vec e%0d nMPSSEEN_F", k+1), 32'(bus.nMPSSEEN_F), 32'(tbl[k].flags[0]));
      check($sformatf("vec e%0d GLITCHCNT", k+1),  32'(bus.GLITCHCNT),  32'(tbl[k].gcnt));
    end

    // MRST back low, then a 5-cycle high pulse that must be rejected as one glitch
    bus.MRST = 1'b0;
    repeat (12) tick();
    check("mrst low MODE", 32'(bus.MODE), 32'(2'b00));
    bus.MRST = 1'b1;
    repeat (5) tick();
    bus.MRST = 1'b0;
    seen_bad = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (bus.MODE_CHG !== 1'b0 || bus.MRST_F !== 1'b0) seen_bad = 1'b1;
    end
    check("glitch5 no MRST_F/MODE_CHG", 32'(seen_bad), 32'(1'b0));
    check("glitch5 GLITCHCNT", 32'(bus.GLITCHCNT), 32'(8'd1));

    // PWRSTAT and MRST rise together: 00 -> 11 on the 10th edge, one MODE_CHG on the 11th
    bus.PWRSTAT = 1'b1;
    bus.MRST    = 1'b1;
    chg_pulses  = 0;
    chg_edge    = 0;
    seen_bad    = 1'b0;
    mode_t9     = 2'bxx;
    mode_t10    = 2'bxx;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 9)  mode_t9  = bus.MODE;
      if (t == 10) mode_t10 = bus.MODE;
      if (bus.MODE == 2'b01 || bus.MODE == 2'b10) seen_bad = 1'b1;
      if (bus.MODE_CHG === 1'b1) begin
        chg_pulses++;
        chg_edge = t;
      end
    end
    check("dual MODE before",     32'(mode_t9),  32'(2'b00));
    check("dual MODE after",      32'(mode_t10), 32'(2'b11));
    check("dual no split MODE",   32'(seen_bad), 32'(1'b0));
    check("dual MODE_CHG pulses", 32'(chg_pulses), 32'(1));
    check("dual MODE_CHG edge",   32'(chg_edge),   32'(11));

    // Short MRST low pulses, one glitch each; the glitch resolves on the following edge
    for (int g = 0; g < 10; g++) begin
      bus.MRST = 1'b0; tick();
      bus.MRST = 1'b1; tick(); tick();
    end
    tick();
    check("glitch x10 GLITCHCNT", 32'(bus.GLITCHCNT), 32'(8'd11));
    for (int g = 0; g < 290; g++) begin
      bus.MRST = 1'b0; tick();
      bus.MRST = 1'b1; tick(); tick();
    end
    tick();
    check("glitch x300 saturated", 32'(bus.GLITCHCNT), 32'(8'd255));
    check("glitch x300 MRST_F",    32'(bus.MRST_F),    32'(1'b1));
    bus.MRST = 1'b0; tick();
    bus.MRST = 1'b1; tick(); tick();
    check("saturation held", 32'(bus.GLITCHCNT), 32'(8'd255));
    bus.GLITCHCLR = 1'b1;
    tick();
    check("clear beats glitch", 32'(bus.GLITCHCNT), 32'(8'd0));
    bus.GLITCHCLR = 1'b0;
    repeat (3) tick();
    check("clear stays 0", 32'(bus.GLITCHCNT), 32'(8'd0));

    // Reset in the middle of an MRST debounce (count 5), then a clean startup replay
    bus.MRST = 1'b0;
    repeat (7) tick();
    check("pre-reset MRST_F held", 32'(bus.MRST_F), 32'(1'b1));
    #1 nRST = 1'b0;
    #1;
    check_reset_values("mid-debounce reset");
    bus.PWRSTAT  = 1'b0;
    bus.MRST     = 1'b0;
    bus.nMPSSEEN = 1'b1;
    repeat (2) tick();
    nRST = 1'b1;
    check_startup("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
